tx_packet_queue: RTL

- Upstream feeder for the serial-link Transmitter: buffers {addr,data} packet requests from a producer in a small FIFO and drives Transmitter's taddr/tdata/send.
- Issues one send per packet, back-to-back when Transmitter holds ready in its last-bit state, so the link carries contiguous 7-bit packets (start, addr[1:0], data[3:0]).
- Keeps saturating sent/dropped packet counters for debug.

---
 rtl/link_pkg.sv | 14 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/tx_packet_queue.sv | 66 ++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared serial-link definitions used by the transmitter, receiver and queue blocks.
package link_pkg;

    localparam int   LINK_AW       = 2;
    localparam int   LINK_DW       = 4;
    localparam int   LINK_PKT_BITS = 7;
    localparam logic START_BIT     = 1'b1;

    typedef struct packed {
        logic [LINK_AW-1:0] addr;
        logic [LINK_DW-1:0] data;
    } link_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: DEPTH x W storage, wrapping pointers, occupancy counter.
// A push is accepted when not full, or when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   accept
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    assign full   = (level == LW'(DEPTH));
    assign empty  = (level == '0);
    assign do_pop = pop && !empty;
    assign accept = push && (!full || do_pop);
    assign rdata  = mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clock) begin
        if (!clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({accept, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage write; contents are intentionally not cleared on reset.
    always_ff @(posedge clock) begin
        if (clear && accept) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tx_packet_queue.sv
// Packet queue feeding the serial-link transmitter: one send per buffered packet,
// back-to-back when the transmitter is ready, plus saturating sent/drop counters.
module tx_packet_queue
    import link_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = LINK_AW,
    parameter int DW    = LINK_DW,
    parameter int CW    = 8
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   push,
    input  logic [AW-1:0]          paddr,
    input  logic [DW-1:0]          pdata,
    input  logic                   pause,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   tx_ready,
    output logic [AW-1:0]          taddr,
    output logic [DW-1:0]          tdata,
    output logic                   send,
    output logic [CW-1:0]          sent_cnt,
    output logic [CW-1:0]          drop_cnt
);

    logic              pop;
    logic              accept;
    logic              drop;
    logic [AW+DW-1:0]  head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clock  (clock),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .wdata  ({paddr, pdata}),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .level  (level),
        .accept (accept)
    );

    // The transmitter ignores send unless ready, so send needs no ready qualification.
    assign send           = !empty && !pause;
    assign pop            = send && tx_ready;
    assign drop           = push && !accept;
    assign {taddr, tdata} = head;

    // Saturating debug counters.
    always_ff @(posedge clock) begin
        if (!clear) begin
            sent_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (pop && (sent_cnt != '1)) sent_cnt <= sent_cnt + CW'(1);
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CW'(1);
        end
    end

endmodule
